// File: rtl/store_align_queue_if.sv
// Store queue bus bundle: MEM-stage store requests, the data-memory write
// port, and the sticky error/drain status.
// master: the environment side (pipeline + memory); slave: the store queue.
interface store_align_queue_if;
   // MEM-stage store request
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [2:0]  st_memop;

   // Data-memory write port
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ack;
   logic        mem_err;

   // Status
   logic        err;
   logic [63:0] err_addr;
   logic        err_clr;
   logic        empty;

   modport master (
      output st_valid, st_addr, st_data, st_memop, mem_ack, mem_err, err_clr,
      input  st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, err, err_addr, empty
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_memop, mem_ack, mem_err, err_clr,
      output st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, err, err_addr, empty
   );
endinterface

// File: rtl/store_align_queue.sv
// Store alignment queue: lane-aligns MEM-stage stores into a 64-bit data word
// plus byte mask, buffers them in a DEPTH-entry FIFO and issues them to data
// memory over a req/ack handshake. Bus errors are dropped and recorded in a
// sticky err/err_addr pair.
// Optional build macro MISALIGN_CHECK_EN: misaligned stores are accepted but
// discarded and reported through the sticky error instead of being truncated.
module store_align_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input logic                clk,
   input logic                rst,
   store_align_queue_if.slave sq
);

   localparam int unsigned           CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);

   // Entry storage: full byte address (low bits kept for err_addr), data, mask
   logic [63:0]      ent_addr_q  [DEPTH];
   logic [63:0]      ent_wdata_q [DEPTH];
   logic [7:0]       ent_wmask_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [63:0]      err_addr_q, err_addr_d;

   logic [63:0]      al_wdata;
   logic [7:0]       al_wmask;
   logic             st_ready;
   logic             accept;
   logic             push;
   logic             pop;
   logic             req;
   logic             err_ev;
   logic [63:0]      err_ev_addr;

   // memop[2] (signedness on the load side) has no meaning for stores
   logic             unused_memop_msb;
   assign unused_memop_msb = sq.st_memop[2];

`ifdef MISALIGN_CHECK_EN
   logic             misaligned;
   logic             mis_q, mis_d;
   logic [63:0]      mis_addr_q, mis_addr_d;
`endif

   // Lane alignment of the incoming store: replicate payload, shift mask
   always_comb begin
      al_wdata = sq.st_data;
      al_wmask = 8'hFF;
      case (sq.st_memop[1:0])
         2'b00: begin
            al_wdata = {8{sq.st_data[7:0]}};
            al_wmask = 8'h01 << sq.st_addr[2:0];
         end
         2'b01: begin
            al_wdata = {4{sq.st_data[15:0]}};
            al_wmask = 8'h03 << {sq.st_addr[2:1], 1'b0};
         end
         2'b10: begin
            al_wdata = {2{sq.st_data[31:0]}};
            al_wmask = 8'h0F << {sq.st_addr[2], 2'b00};
         end
         default: begin
            al_wdata = sq.st_data;
            al_wmask = 8'hFF;
         end
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   // Natural-alignment check on the incoming store
   always_comb begin
      misaligned = 1'b0;
      case (sq.st_memop[1:0])
         2'b01:   misaligned = sq.st_addr[0];
         2'b10:   misaligned = |sq.st_addr[1:0];
         2'b11:   misaligned = |sq.st_addr[2:0];
         default: misaligned = 1'b0;
      endcase
   end
`endif

   // Handshake qualifiers; ready looks only at the registered count, so a
   // same-cycle pop never makes room for a push
   always_comb begin
      st_ready = ~rst & (count_q != CNT_FULL);
      accept   = sq.st_valid & st_ready;
      req      = (count_q != '0);
      pop      = req & sq.mem_ack;
`ifdef MISALIGN_CHECK_EN
      push     = accept & ~misaligned;
`else
      push     = accept;
`endif
   end

   // Pointer and occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   // Remember an accepted-but-discarded misaligned store for one cycle
   always_comb begin
      mis_d      = accept & misaligned;
      mis_addr_d = mis_q ? mis_addr_q : '0;
      if (accept & misaligned) begin
         mis_addr_d = sq.st_addr;
      end
   end
`endif

   // Sticky error: first error latches its address; a clear coinciding with
   // a new error yields the new error
   always_comb begin
      err_ev      = 1'b0;
      err_ev_addr = '0;
      if (pop & sq.mem_err) begin
         err_ev      = 1'b1;
         err_ev_addr = ent_addr_q[rd_ptr_q];
      end
`ifdef MISALIGN_CHECK_EN
      else if (mis_q) begin
         err_ev      = 1'b1;
         err_ev_addr = mis_addr_q;
      end
`endif
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (err_ev && (!err_q || sq.err_clr)) begin
         err_d      = 1'b1;
         err_addr_d = err_ev_addr;
      end else if (sq.err_clr) begin
         err_d      = 1'b0;
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

`ifdef MISALIGN_CHECK_EN
   // Pending misalignment report register
   always_ff @(posedge clk) begin
      if (rst) begin
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end
`endif

   // Entry write port; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr_q[wr_ptr_q]  <= sq.st_addr;
         ent_wdata_q[wr_ptr_q] <= al_wdata;
         ent_wmask_q[wr_ptr_q] <= al_wmask;
      end
   end

   // Outputs: head entry while requesting, zeros otherwise
   always_comb begin
      sq.st_ready  = st_ready;
      sq.mem_req   = req;
      sq.mem_addr  = '0;
      sq.mem_wdata = '0;
      sq.mem_wmask = '0;
      if (req) begin
         sq.mem_addr  = {ent_addr_q[rd_ptr_q][63:3], 3'b000};
         sq.mem_wdata = ent_wdata_q[rd_ptr_q];
         sq.mem_wmask = ent_wmask_q[rd_ptr_q];
      end
      sq.err      = err_q;
      sq.err_addr = err_addr_q;
      sq.empty    = ~req;
   end

endmodule

// File: tb/tb_store_align_queue.sv
// Bench for store_align_queue: queue-level reference model checked every
// cycle, plus directed literal expectations at key points.
module tb_store_align_queue;
   localparam int DEPTH = 2;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   store_align_queue_if sif ();

   store_align_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sq  (sif)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        mq[$];
   bit          m_valid = 0;
   bit          m_err;
   logic [63:0] m_err_addr;
   bit          m_mis;
   logic [63:0] m_mis_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ent_t align(input logic [63:0] a, input logic [63:0] d,
                                  input logic [2:0] op);
      ent_t e;
      int   off;
      off     = int'(a % 64'd8);
      e.addr  = a;
      case (op[1:0])
         2'd0: begin
            e.wdata = 64'(d[7:0]) * 64'h0101010101010101;
            e.wmask = 8'(1 << off);
         end
         2'd1: begin
            e.wdata = 64'(d[15:0]) * 64'h0001000100010001;
            e.wmask = 8'(3 << ((off / 2) * 2));
         end
         2'd2: begin
            e.wdata = 64'(d[31:0]) * 64'h0000000100000001;
            e.wmask = 8'(15 << ((off / 4) * 4));
         end
         default: begin
            e.wdata = d;
            e.wmask = 8'hFF;
         end
      endcase
      return e;
   endfunction

   function automatic bit is_misaligned(input logic [63:0] a, input logic [2:0] op);
      int sz;
      sz = 1 << op[1:0];
      return (int'(a % 64'd8) % sz) != 0;
   endfunction

   // Model update on each clock edge from the inputs seen at that edge
   always @(posedge clk) begin
      bit          do_pop;
      bit          do_push;
      bit          ev;
      logic [63:0] ev_a;
      ent_t        e;
      if (rst) begin
         mq.delete();
         m_err      = 0;
         m_err_addr = '0;
         m_mis      = 0;
         m_mis_addr = '0;
         m_valid    = 1;
      end else begin
         do_pop  = (mq.size() > 0) && sif.mem_ack;
         do_push = sif.st_valid && (mq.size() < DEPTH);
         ev      = 0;
         ev_a    = '0;
         if (do_pop && sif.mem_err) begin
            ev   = 1;
            ev_a = mq[0].addr;
         end else if (m_mis) begin
            ev   = 1;
            ev_a = m_mis_addr;
         end
         m_mis = 0;
         if (ev) begin
            if (!m_err || sif.err_clr) begin
               m_err      = 1;
               m_err_addr = ev_a;
            end
         end else if (sif.err_clr) begin
            m_err = 0;
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e = align(sif.st_addr, sif.st_data, sif.st_memop);
`ifdef MISALIGN_CHECK_EN
            if (is_misaligned(sif.st_addr, sif.st_memop)) begin
               m_mis      = 1;
               m_mis_addr = sif.st_addr;
            end else begin
               mq.push_back(e);
            end
`else
            mq.push_back(e);
`endif
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("st_ready", 64'(sif.st_ready), 64'(!rst && (mq.size() < DEPTH)));
         chk("mem_req", 64'(sif.mem_req), 64'(mq.size() != 0));
         chk("empty", 64'(sif.empty), 64'(mq.size() == 0));
         chk("err", 64'(sif.err), 64'(m_err));
         chk("err_addr", sif.err_addr, m_err_addr);
         if (mq.size() != 0) begin
            chk("mem_addr", sif.mem_addr, {mq[0].addr[63:3], 3'b000});
            chk("mem_wdata", sif.mem_wdata, mq[0].wdata);
            chk("mem_wmask", 64'(sif.mem_wmask), 64'(mq[0].wmask));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_st(input logic [63:0] a, input logic [63:0] d, input logic [2:0] op);
      sif.st_valid = 1'b1;
      sif.st_addr  = a;
      sif.st_data  = d;
      sif.st_memop = op;
   endtask

   initial begin
      rst          = 1'b1;
      sif.st_valid = 1'b0;
      sif.st_addr  = '0;
      sif.st_data  = '0;
      sif.st_memop = '0;
      sif.mem_ack  = 1'b0;
      sif.mem_err  = 1'b0;
      sif.err_clr  = 1'b0;
      cyc();
      cyc();
      chk("rst_mem_req", 64'(sif.mem_req), 64'd0);
      chk("rst_empty", 64'(sif.empty), 64'd1);
      chk("rst_wmask", 64'(sif.mem_wmask), 64'd0);
      chk("rst_wdata", sif.mem_wdata, 64'd0);
      chk("rst_addr", sif.mem_addr, 64'd0);
      chk("rst_ready", 64'(sif.st_ready), 64'd0);
      chk("rst_err", 64'(sif.err), 64'd0);
      rst = 1'b0;
      cyc();
      chk("ready_after_rst", 64'(sif.st_ready), 64'd1);

      // 1: byte store, visible the cycle after acceptance
      set_st(64'h80000005, 64'hAB, 3'd0);
      cyc();
      sif.st_valid = 1'b0;
      chk("t1_req", 64'(sif.mem_req), 64'd1);
      chk("t1_addr", sif.mem_addr, 64'h80000000);
      chk("t1_mask", 64'(sif.mem_wmask), 64'h20);
      chk("t1_wdata", sif.mem_wdata, 64'hABABABABABABABAB);
      sif.mem_ack = 1'b1;
      cyc();
      chk("t1_empty", 64'(sif.empty), 64'd1);
      cyc();  // ack while idle is ignored
      chk("t1_idle_ack", 64'(sif.mem_req), 64'd0);
      sif.mem_ack = 1'b0;

      // 2: fill, hold, back-to-back drain
      set_st(64'h80000002, 64'h1234, 3'd1);
      cyc();
      set_st(64'h80000004, 64'hDEADBEEF, 3'd2);
      cyc();
      chk("t2_full", 64'(sif.st_ready), 64'd0);
      chk("t2_mask0", 64'(sif.mem_wmask), 64'h0C);
      chk("t2_wdata0", sif.mem_wdata, 64'h1234123412341234);
      set_st(64'h0, 64'h99, 3'd0);  // refused while full
      cyc();
      sif.st_valid = 1'b0;
      chk("t2_hold", 64'(sif.mem_wmask), 64'h0C);
      sif.mem_ack = 1'b1;
      cyc();
      chk("t2_req1", 64'(sif.mem_req), 64'd1);
      chk("t2_mask1", 64'(sif.mem_wmask), 64'hF0);
      chk("t2_wdata1", sif.mem_wdata, 64'hDEADBEEFDEADBEEF);
      cyc();
      sif.mem_ack = 1'b0;
      chk("t2_empty", 64'(sif.empty), 64'd1);

      // 3: push and pop together at count 1
      set_st(64'h10, 64'h11, 3'd0);
      cyc();
      set_st(64'h21, 64'h22, 3'b100);
      sif.mem_ack = 1'b1;
      cyc();
      sif.st_valid = 1'b0;
      sif.mem_ack  = 1'b0;
      chk("t3_req", 64'(sif.mem_req), 64'd1);
      chk("t3_addr", sif.mem_addr, 64'h20);
      chk("t3_mask", 64'(sif.mem_wmask), 64'h02);
      chk("t3_ready", 64'(sif.st_ready), 64'd1);
      sif.mem_ack = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
      chk("t3_empty", 64'(sif.empty), 64'd1);

      // 4: sticky error, clear, clear racing a new error
      set_st(64'h1000, 64'h0123456789ABCDEF, 3'd3);
      cyc();
      sif.st_valid = 1'b0;
      chk("t4_mask", 64'(sif.mem_wmask), 64'hFF);
      chk("t4_wdata", sif.mem_wdata, 64'h0123456789ABCDEF);
      sif.mem_ack = 1'b1;
      sif.mem_err = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
      sif.mem_err = 1'b0;
      chk("t4_err", 64'(sif.err), 64'd1);
      chk("t4_err_addr", sif.err_addr, 64'h1000);
      chk("t4_dropped", 64'(sif.empty), 64'd1);
      set_st(64'h2008, 64'h5, 3'd3);
      cyc();
      sif.st_valid = 1'b0;
      sif.mem_ack  = 1'b1;
      sif.mem_err  = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
      sif.mem_err = 1'b0;
      chk("t4_err_keep", sif.err_addr, 64'h1000);
      sif.err_clr = 1'b1;
      cyc();
      sif.err_clr = 1'b0;
      chk("t4_clr", 64'(sif.err), 64'd0);
      set_st(64'h4003, 64'h7, 3'd0);
      cyc();
      sif.st_valid = 1'b0;
      sif.mem_ack  = 1'b1;
      sif.mem_err  = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
      sif.mem_err = 1'b0;
      chk("t4_err2_addr", sif.err_addr, 64'h4003);
      set_st(64'h5001, 64'h8, 3'd0);
      cyc();
      sif.st_valid = 1'b0;
      sif.mem_ack  = 1'b1;
      sif.mem_err  = 1'b1;
      sif.err_clr  = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
      sif.mem_err = 1'b0;
      sif.err_clr = 1'b0;
      chk("t4_clr_race_err", 64'(sif.err), 64'd1);
      chk("t4_clr_race_addr", sif.err_addr, 64'h5001);

      // 5: reset with pending entries and sticky error set
      set_st(64'h6000, 64'h1, 3'd0);
      cyc();
      set_st(64'h6001, 64'h2, 3'd0);
      cyc();
      sif.st_valid = 1'b0;
      chk("t5_req", 64'(sif.mem_req), 64'd1);
      rst = 1'b1;
      cyc();
      chk("t5_req_rst", 64'(sif.mem_req), 64'd0);
      chk("t5_empty", 64'(sif.empty), 64'd1);
      chk("t5_err", 64'(sif.err), 64'd0);
      chk("t5_err_addr", sif.err_addr, 64'd0);
      chk("t5_ready_rst", 64'(sif.st_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("t5_ready", 64'(sif.st_ready), 64'd1);
      cyc();

      // 6: misaligned word store
      set_st(64'h3002, 64'hCAFEF00D, 3'd2);
      cyc();
      sif.st_valid = 1'b0;
`ifdef MISALIGN_CHECK_EN
      chk("t6_req", 64'(sif.mem_req), 64'd0);
      cyc();
      chk("t6_err", 64'(sif.err), 64'd1);
      chk("t6_err_addr", sif.err_addr, 64'h3002);
`else
      chk("t6_mask", 64'(sif.mem_wmask), 64'h0F);
      chk("t6_addr", sif.mem_addr, 64'h3000);
      chk("t6_wdata", sif.mem_wdata, 64'hCAFEF00DCAFEF00D);
      sif.mem_ack = 1'b1;
      cyc();
      sif.mem_ack = 1'b0;
`endif
      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/store_align_queue.md
Name: store_align_queue

Overview:
- Store-side counterpart of the writeback load-data extractor.
- Accepts store requests from the MEM stage (address, raw register data, MemOp).
- Lane-aligns the data and generates an 8-bit byte write mask for the 64-bit data port.
- Buffers stores in a small FIFO and issues them to data memory over a req/ack handshake, so the pipeline stalls only when the queue is full.

Parameters:
DEPTH, 2, store queue entries; power of two, minimum 2.
PTR_W, 1, log2(DEPTH).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
st_valid  in  1  store request this cycle
st_ready  out  1  queue can accept; a store is accepted when st_valid && st_ready
st_addr  in  64  byte address
st_data  in  64  rs2 value; low bits hold the payload
st_memop  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 double; [2] ignored
mem_req  out  1  write request valid
mem_addr  out  64  doubleword-aligned address
mem_wdata  out  64  lane-replicated data
mem_wmask  out  8  byte enables
mem_ack  in  1  memory accepts the head entry this cycle
mem_err  in  1  bus error, qualified by mem_ack
err  out  1  sticky error flag
err_addr  out  64  byte address of the first faulting store
err_clr  in  1  clears err
empty  out  1  queue holds no entries (fence/drain indication)

Behaviour:
- Reset values: queue pointers 0, count 0, err 0, err_addr 0.
  - Consequently mem_req 0, empty 1, mem_wmask 0, mem_wdata 0, mem_addr 0.
  - st_ready is forced 0 while rst is high.
- Alignment is computed at enqueue, combinationally from the st_* inputs, and stored per entry as {addr, wdata, wmask}.
  - mem_addr = {st_addr[63:3], 3'b000}
  - byte: wdata = {8{d[7:0]}}, wmask = 8'h01 << a[2:0]
  - half: wdata = {4{d[15:0]}}, wmask = 8'h03 << {a[2:1], 1'b0}
  - word: wdata = {2{d[31:0]}}, wmask = 8'h0F << {a[2], 2'b00}
  - double: wdata = d, wmask = 8'hFF
- Queue behaviour:
  - st_ready = ~rst && (count != DEPTH); it depends on registered count only.
  - A same-cycle pop does not free a slot for a push in that cycle.
  - Push writes the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Issue behaviour:
  - mem_req = (count != 0), driven from registers.
  - mem_addr, mem_wdata and mem_wmask show the head entry.
  - Outputs hold stable while mem_req && ~mem_ack.
  - A pop occurs when mem_req && mem_ack; rd_ptr increments modulo DEPTH.
  - Back-to-back issue: the next head is presented in the cycle after ack with mem_req still high. No bubble is inserted.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - With count==1, the pushed entry becomes head on the next cycle.
- Zero latency through an empty queue is not provided.
  - A store accepted in cycle N appears on mem_req at cycle N+1 at the earliest.
- Error handling:
  - If mem_ack && mem_err: the entry still pops (dropped, no retry).
  - If err==0, set err=1 and err_addr = the faulting entry's byte address (stored low bits kept per entry).
  - Later errors do not overwrite err_addr.
  - err_clr clears err. If err_clr and a new error arrive in the same cycle, the new error wins: err=1 with the new address.
- mem_ack while mem_req==0 is ignored.
- empty = (count==0).
- Reset mid-operation discards all entries, including an outstanding unacked request. mem_req drops the cycle after rst.

Optional Feature:
- Macro: MISALIGN_CHECK_EN
- Defined:
  - A store whose address is not naturally aligned is still accepted (st_ready handshake completes) but is not enqueued.
    - half: a[0]!=0
    - word: a[1:0]!=0
    - double: a[2:0]!=0
  - On the next cycle, err sets per the sticky rule with err_addr = st_addr.
- Undefined:
  - No check is made; misaligned addresses are truncated by the shift rules above.
  - This matches load-side extraction, e.g. a half at a[2:0]=001 writes mask 8'h03.

Test Plan:
1. Reset, then st_valid byte addr=0x80000005 data=0xAB. Cycle+1: mem_req=1, mem_addr=0x80000000, mem_wmask=8'h20, mem_wdata=0xABABABABABABABAB.
2. Hold mem_ack=0 and push 2 stores (half @0x..02 data 0x1234; word @0x..04 data 0xDEADBEEF). After that, st_ready=0 and outputs stay fixed at mask 8'h0C. Then ack twice in consecutive cycles: second head mask=8'hF0, no bubble, then empty=1.
3. count=1, mem_ack=1, and a new push in the same cycle. The next cycle shows the new entry, count stays 1, and there is no mem_req gap.
4. Double store @0x1000 acked with mem_err=1. err=1, err_addr=0x1000. A second error @0x2008 leaves err_addr=0x1000. Then err_clr gives err=0.
5. Assert rst with 2 entries pending and mem_req high. Next cycle: mem_req=0, empty=1, err=0, st_ready=0 during rst and 1 after.
6. (MISALIGN_CHECK_EN) Word store @0x3002. Handshake completes, mem_req stays 0, err=1, err_addr=0x3002. Without the macro: mem_wmask=8'h0F, mem_addr=0x3000.
